// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcodes, instruction layout, IMEM sizing and loader states.
// Building with LOADER_CHECKSUM_EN adds the CHECK state used by gpu_imem_loader.
package gpu_pkg;

   localparam int IMEM_DEPTH_DEFAULT = 64;
   localparam int INSTR_W_DEFAULT    = 32;

   localparam logic [5:0] OP_NOP    = 6'b000000;
   localparam logic [5:0] OP_VADD   = 6'b000001;
   localparam logic [5:0] OP_VLOAD  = 6'b100000;
   localparam logic [5:0] OP_VSTORE = 6'b100001;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [2:0]  dest;
      logic [2:0]  src1;
      logic [2:0]  src2;
      logic        rsvd;
      logic [15:0] mask;
   } instr_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STREAM = 3'd1,
      ST_PAD    = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK  = 3'd3,
`endif
      ST_RUN    = 3'd4
   } loader_state_t;

   // A session must carry at least one word and must fit in IMEM.
   function automatic logic len_in_range(input int unsigned len, input int unsigned depth);
      return (len != 0) && (len <= depth);
   endfunction

endpackage

// File: rtl/gpu_imem_loader.sv
// Streams host instruction words into IMEM from address 0, pads with NOPs, then releases
// GPU_Core from reset. Optional checksum stage enabled by LOADER_CHECKSUM_EN.
module gpu_imem_loader
   import gpu_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
   parameter int INSTR_W    = INSTR_W_DEFAULT,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic [ADDR_W:0]    load_len,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [INSTR_W-1:0] s_data,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_waddr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_rst_n,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(IMEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t ST_BODY_DONE = ST_CHECK;
`else
   localparam loader_state_t ST_BODY_DONE = ST_RUN;
`endif

   // Handshake: a word transfers on a rising edge where s_valid && s_ready; s_ready
   // depends only on the registered state, never on s_valid.
   loader_state_t     state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              handshake;
   logic              start_ok;
`ifdef LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] csum;
`endif

`ifdef LOADER_CHECKSUM_EN
   assign s_ready = (state == ST_STREAM) || (state == ST_CHECK);
`else
   assign s_ready = (state == ST_STREAM);
`endif
   assign busy      = (state != ST_IDLE) && (state != ST_RUN);
   assign handshake = s_valid && s_ready;
   assign cnt_nxt   = cnt + 1'b1;
   assign start_ok  = len_in_range(32'(load_len), IMEM_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr       <= '0;
         len        <= '0;
         cnt        <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         core_rst_n <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            ST_IDLE, ST_RUN: begin
               // First RUN cycle coincides with the final write; release the core one cycle later.
               if (state == ST_RUN) begin
                  core_rst_n <= 1'b1;
                  done       <= !core_rst_n;
               end
               if (load_start) begin
                  core_rst_n <= 1'b0;
                  done       <= 1'b0;
                  if (start_ok) begin
                     err   <= 1'b0;
                     len   <= load_len;
                     addr  <= '0;
                     cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum  <= '0;
`endif
                     state <= ST_STREAM;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end

            ST_STREAM: begin
               if (handshake) begin
                  imem_we    <= 1'b1;
                  imem_waddr <= addr;
                  imem_wdata <= s_data;
                  cnt        <= cnt_nxt;
`ifdef LOADER_CHECKSUM_EN
                  csum       <= csum + s_data;
`endif
                  if (cnt_nxt == len) begin
                     // A full-depth program leaves addr parked on the last word.
                     if (len < DEPTH_LEN) begin
                        addr  <= addr + 1'b1;
                        state <= ST_PAD;
                     end else begin
                        state <= ST_BODY_DONE;
                     end
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end

            ST_PAD: begin
               imem_we    <= 1'b1;
               imem_waddr <= addr;
               imem_wdata <= '0;
               if (addr == LAST_ADDR) begin
                  state <= ST_BODY_DONE;
               end else begin
                  addr <= addr + 1'b1;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (handshake) begin
                  if (s_data == csum) begin
                     state <= ST_RUN;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
`endif

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_imem_loader.sv
// Scoreboard bench for gpu_imem_loader: every session pushes its expected IMEM image,
// and a negedge monitor pops and compares each imem_we beat.
module tb_gpu_imem_loader;

   localparam int DEPTH = 64;

   logic        clk;
   logic        rst;
   logic        load_start;
   logic [6:0]  load_len;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        core_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   gpu_imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          wr_total = 0;
   int          done_total = 0;
   int          last_we_cyc = -1;
   int          rise_cyc = -1;
   int          done_cyc = -1;
   logic        prev_rst_n = 1'b0;
   logic [37:0] exp_q[$];
   logic [37:0] exp_e;
   logic [31:0] prog[DEPTH];

   always @(posedge clk) cyc++;

   // monitor / scoreboard
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_total++;
         last_we_cyc = cyc;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: addr %0d data %h, no write expected", imem_waddr, imem_wdata);
         end else begin
            exp_e = exp_q.pop_front();
            if ({imem_waddr, imem_wdata} === exp_e) n_pass++;
            else $display("FAIL imem_write: got addr %0d data %h, expected addr %0d data %h",
                          imem_waddr, imem_wdata, exp_e[37:32], exp_e[31:0]);
         end
      end
      if (done === 1'b1) begin
         done_total++;
         done_cyc = cyc;
      end
      if (core_rst_n === 1'b1 && prev_rst_n !== 1'b1) rise_cyc = cyc;
      prev_rst_n = core_rst_n;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: bound expired", name);
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_image(input int len);
      for (int i = 0; i < DEPTH; i++)
         exp_q.push_back({6'(i), (i < len) ? prog[i] : 32'h0});
   endtask

   task automatic do_start(input logic [6:0] len);
      load_start = 1'b1;
      load_len   = len;
      tick();
      load_start = 1'b0;
      load_len   = '0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      int t = 0;
      s_valid = 1'b1;
      s_data  = w;
      while (s_ready !== 1'b1 && t < 200) begin
         tick();
         t++;
      end
      if (s_ready !== 1'b1) fail("s_ready_wait");
      tick();
      s_valid = 1'b0;
      s_data  = '0;
      repeat (gap) tick();
   endtask

   task automatic wait_run(input string name, input int wr0, input int dn0);
      int t = 0;
      while (core_rst_n !== 1'b1 && t < 300) begin
         tick();
         t++;
      end
      if (core_rst_n !== 1'b1) fail({name, "_run_wait"});
      tick();
      tick();
      check({name, "_writes"}, wr_total - wr0, DEPTH);
      check({name, "_done_pulses"}, done_total - dn0, 1);
      check({name, "_done_with_release"}, done_cyc, rise_cyc);
`ifndef LOADER_CHECKSUM_EN
      check({name, "_release_after_last_write"}, rise_cyc, last_we_cyc + 1);
`endif
      check({name, "_queue_drained"}, exp_q.size(), 0);
      check({name, "_core_rst_n"}, core_rst_n, 1);
      check({name, "_busy_low"}, busy, 0);
   endtask

   task automatic run_session(input string name, input int len, input int gap,
                              input logic [31:0] csum_word);
      int wr0 = wr_total;
      int dn0 = done_total;
      push_image(len);
      do_start(7'(len));
      check({name, "_busy"}, busy, 1);
      check({name, "_core_held"}, core_rst_n, 0);
      check({name, "_err_clear"}, err, 0);
      for (int i = 0; i < len; i++) send_word(prog[i], gap);
`ifdef LOADER_CHECKSUM_EN
      send_word(csum_word, 0);
`else
      if (csum_word == 32'hFFFF_FFFF) tick();
`endif
      wait_run(name, wr0, dn0);
   endtask

   task automatic load_test1_words();
      prog[0] = 32'h0414FFFF;
      prog[1] = 32'h8430FFFF;
      prog[2] = 32'h8230FFFF;
   endtask

   initial begin
      logic [31:0] sum;
      int wr0;
      int dn0;
      rst        = 1'b1;
      load_start = 1'b0;
      load_len   = '0;
      s_valid    = 1'b0;
      s_data     = '0;
      tick();
      tick();
      check("reset_imem_we", imem_we, 0);
      check("reset_core_rst_n", core_rst_n, 0);
      check("reset_outputs", {s_ready, busy, done, err}, 4'b0000);
      rst = 1'b0;
      tick();

      // 1: program load, s_valid held high
      load_test1_words();
      run_session("t1_load", 3, 0, 32'h0A76FFFD);

      // 2: gappy host, load_start issued from RUN
      run_session("t2_gappy", 3, 1, 32'h0A76FFFD);

      // 3: bad lengths (first one arrives in RUN)
      wr0 = wr_total;
      dn0 = done_total;
      do_start(7'd0);
      check("t3_len0_err", err, 1);
      check("t3_len0_core_held", core_rst_n, 0);
      check("t3_len0_idle", {busy, s_ready}, 2'b00);
      repeat (3) tick();
      do_start(7'd65);
      check("t3_len65_err", err, 1);
      check("t3_len65_idle", {busy, s_ready}, 2'b00);
      repeat (5) tick();
      check("t3_no_writes", wr_total - wr0, 0);
      check("t3_core_held", core_rst_n, 0);
      check("t3_no_done", done_total - dn0, 0);

      // 4: full-depth program, no padding
      sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
         prog[i] = 32'h1000_0000 | (32'(i) << 8) | 32'(i);
         sum += prog[i];
      end
      run_session("t4_full", DEPTH, 0, sum);

      // 5: reset after two handshakes, then reload and reload-from-RUN
      load_test1_words();
      exp_q.push_back({6'd0, 32'h0414FFFF});
      exp_q.push_back({6'd1, 32'h8430FFFF});
      do_start(7'd3);
      send_word(prog[0], 0);
      send_word(prog[1], 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_we_addr_data", {imem_we, imem_waddr, imem_wdata}, 39'h0);
      check("t5_rst_flags", {s_ready, busy, done, err, core_rst_n}, 5'b00000);
      check("t5_rst_queue", exp_q.size(), 0);
      tick();
      run_session("t5_reload", 3, 0, 32'h0A76FFFD);
      run_session("t5_reload_from_run", 3, 0, 32'h0A76FFFD);

`ifdef LOADER_CHECKSUM_EN
      // 6: wrong checksum word holds the core and is never written
      wr0 = wr_total;
      dn0 = done_total;
      push_image(3);
      do_start(7'd3);
      for (int i = 0; i < 3; i++) send_word(prog[i], 0);
      send_word(32'h0A76FFFE, 0);
      check("t6_bad_csum_err", err, 1);
      check("t6_bad_csum_idle", busy, 0);
      repeat (4) tick();
      check("t6_bad_csum_core_held", core_rst_n, 0);
      check("t6_bad_csum_writes", wr_total - wr0, DEPTH);
      check("t6_bad_csum_no_done", done_total - dn0, 0);
      check("t6_bad_csum_queue", exp_q.size(), 0);
`endif

      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
